// File: rtl/pll_reset_ctrl_pkg.sv
// pll_reset_ctrl_pkg
// Shared definitions for the PLL reset sequencer: FSM state encoding and a
// small elaboration-time helper used to size the sequencing timer.
package pll_reset_ctrl_pkg;

    // Sequencer states; the encoding is fixed so that debug taps and any
    // external state decode agree with the RTL.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        PERIPH_UP = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Larger of two integers, used for timer sizing at elaboration.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_1bit.sv
// sync_1bit
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage to 0
//   d    - asynchronous input level
//   q    - synchronised output (last stage)
// Parameter N_STAGES (>= 2) sets the number of flops in the chain.
module sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] sync_r;

    // Shift chain: stage 0 may go metastable, later stages resolve it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {N_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[N_STAGES-2:0], d};
        end
    end

    assign q = sync_r[N_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Turns a raw, asynchronous PLL lock indication into ordered, synchronous,
// active-high resets. Lock must be held for STABLE_CYCLES consecutive
// synchronised cycles before the peripheral reset releases; the core reset
// follows CORE_DELAY cycles later. Loss of lock or a software request
// re-asserts both resets and restarts the sequence.
// Ports:
//   clk             - PLL output clock, sole clock
//   rst             - synchronous active-high power-on reset
//   pll_locked      - raw PLL lock, asynchronous to clk
//   sw_reset_req    - one-cycle software reset request
//   rst_periph      - registered reset for interconnect/peripherals
//   rst_core        - registered reset for the processor core
//   ready           - high only when both resets are released
//   lock_loss_count - saturating count of lock losses after release
// Build option: define PLL_RESET_CTRL_LOSS_COUNT_EN to implement the
// lock-loss counter; otherwise lock_loss_count is tied to zero.
module pll_reset_ctrl
    import pll_reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int CORE_DELAY    = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sw_reset_req,
    output logic             rst_periph,
    output logic             rst_core,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int TIMER_W = $clog2(max_int(STABLE_CYCLES, CORE_DELAY) + 1);
    localparam logic [TIMER_W-1:0] STAB_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CORE_LAST = TIMER_W'(CORE_DELAY - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic               lock_s;
    state_t             state_r;
    state_t             state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic               rst_periph_s;
    logic               rst_core_s;
    logic               ready_s;
    logic               rst_periph_r;
    logic               rst_core_r;
    logic               ready_r;

    sync_1bit #(
        .N_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= WAIT_LOCK;
            timer_r      <= {TIMER_W{1'b0}};
            rst_periph_r <= 1'b1;
            rst_core_r   <= 1'b1;
            ready_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            rst_periph_r <= rst_periph_s;
            rst_core_r   <= rst_core_s;
            ready_r      <= ready_s;
        end
    end

    // Next-state and timer logic.
    // The lock sample that moves WAIT_LOCK to STABILISE is the first of the
    // STABLE_CYCLES required, so the timer enters STABILISE at 1; the
    // peripheral reset then falls on exactly the STABLE_CYCLES-th sample.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            WAIT_LOCK: begin
                timer_s = {TIMER_W{1'b0}};
                if (sw_reset_req) begin
                    state_s = WAIT_LOCK;
                end else if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_s = PERIPH_UP;
                    end else begin
                        state_s = STABILISE;
                        timer_s = TIMER_ONE;
                    end
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            STABILISE: begin
                if (sw_reset_req || !lock_s) begin
                    state_s = WAIT_LOCK;
                    timer_s = {TIMER_W{1'b0}};
                end else if (timer_r == STAB_LAST) begin
                    state_s = PERIPH_UP;
                    timer_s = {TIMER_W{1'b0}};
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            PERIPH_UP: begin
                if (sw_reset_req || !lock_s) begin
                    state_s = WAIT_LOCK;
                    timer_s = {TIMER_W{1'b0}};
                end else if (timer_r == CORE_LAST) begin
                    state_s = RUN;
                    timer_s = {TIMER_W{1'b0}};
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            RUN: begin
                if (sw_reset_req || !lock_s) begin
                    state_s = WAIT_LOCK;
                    timer_s = {TIMER_W{1'b0}};
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = WAIT_LOCK;
                timer_s = {TIMER_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered resets change on
    // the same edge as the state transition.
    always_comb begin
        rst_periph_s = 1'b1;
        rst_core_s   = 1'b1;
        ready_s      = 1'b0;
        case (state_s)
            PERIPH_UP: begin
                rst_periph_s = 1'b0;
            end
            RUN: begin
                rst_periph_s = 1'b0;
                rst_core_s   = 1'b0;
                ready_s      = 1'b1;
            end
            default: begin
                rst_periph_s = 1'b1;
                rst_core_s   = 1'b1;
                ready_s      = 1'b0;
            end
        endcase
    end

    assign rst_periph = rst_periph_r;
    assign rst_core   = rst_core_r;
    assign ready      = ready_r;

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
    // Only a lock drop after the peripheral reset has released is a loss;
    // it wins over a simultaneous software request.
    logic             loss_event_s;
    logic [CNT_W-1:0] loss_cnt_r;

    assign loss_event_s = ((state_r == PERIPH_UP) || (state_r == RUN)) && !lock_s;

    // Saturating lock-loss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_r <= {CNT_W{1'b0}};
        end else if (loss_event_s && (loss_cnt_r != {CNT_W{1'b1}})) begin
            loss_cnt_r <= loss_cnt_r + CNT_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_count = loss_cnt_r;
`else
    assign lock_loss_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl
// Self-checking bench for pll_reset_ctrl with STABLE_CYCLES=8, CORE_DELAY=4,
// SYNC_STAGES=2, CNT_W=2. Expected outputs come from the documented release
// timing (cycles counted from the pll_locked change) and are queued when a
// stimulus cycle is driven, then popped and compared half a clock after the
// edge. The lock-loss count expectation follows PLL_RESET_CTRL_LOSS_COUNT_EN.
module tb_pll_reset_ctrl;

    localparam int SYNC_N = 2;
    localparam int STAB_N = 8;
    localparam int CORE_N = 4;
    localparam int CNT_W  = 2;

`ifdef PLL_RESET_CTRL_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             pll_locked;
    logic             sw_reset_req;
    logic             rst_periph;
    logic             rst_core;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_count;

    typedef struct {
        logic       ep;
        logic       ec;
        logic       er;
        logic [1:0] ecnt;
        string      nm;
    } exp_t;

    typedef struct {
        logic l;
        logic s;
        logic r;
        logic ep;
        logic ec;
        logic er;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[22];
    int   checks = 0;
    int   errors = 0;
    int   loss_exp = 0;

    pll_reset_ctrl #(
        .SYNC_STAGES   (SYNC_N),
        .STABLE_CYCLES (STAB_N),
        .CORE_DELAY    (CORE_N),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .sw_reset_req    (sw_reset_req),
        .rst_periph      (rst_periph),
        .rst_core        (rst_core),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] cnt_now();
        return CNT_EN ? 2'(loss_exp) : 2'd0;
    endfunction

    task automatic bump_loss();
        if (loss_exp < 3) loss_exp = loss_exp + 1;
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic apply(input logic l, input logic s, input logic r,
                         input logic ep, input logic ec, input logic er,
                         input string nm);
        exp_t e;
        pll_locked   = l;
        sw_reset_req = s;
        rst          = r;
        sb.push_back('{ep: ep, ec: ec, er: er, ecnt: cnt_now(), nm: nm});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rst_periph, rst_core, ready, lock_loss_count} !== {e.ep, e.ec, e.er, e.ecnt}) begin
            errors++;
            $display("FAIL %s @%0t: got periph=%0b core=%0b ready=%0b cnt=%0d, expected periph=%0b core=%0b ready=%0b cnt=%0d",
                     e.nm, $time, rst_periph, rst_core, ready, lock_loss_count,
                     e.ep, e.ec, e.er, e.ecnt);
        end
    endtask

    // Hold lock high for n cycles. off is the synchroniser latency still to
    // be paid (SYNC_N from a cleared synchroniser, 0 if lock_s is already 1).
    task automatic bringup(input int n, input int off, input string nm);
        for (int k = 1; k <= n; k++) begin
            apply(1'b1, 1'b0, 1'b0,
                  (k < off + STAB_N), (k < off + STAB_N + CORE_N),
                  (k >= off + STAB_N + CORE_N), nm);
        end
    endtask

    // Drop lock for n cycles starting in RUN; resets assert on the edge
    // that sees the synchronised drop.
    task automatic drop_from_run(input int n, input string nm);
        for (int k = 1; k <= n; k++) begin
            if (k == SYNC_N + 1) bump_loss();
            if (k <= SYNC_N) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nm);
            else             apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, nm);
        end
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;

        // Table: reset, idle without lock, then a clean bring-up.
        for (int i = 0; i < 3; i++) tbl[i] = '{l: 1'b0, s: 1'b0, r: 1'b1, ep: 1'b1, ec: 1'b1, er: 1'b0};
        for (int i = 3; i < 6; i++) tbl[i] = '{l: 1'b0, s: 1'b0, r: 1'b0, ep: 1'b1, ec: 1'b1, er: 1'b0};
        for (int k = 1; k <= 16; k++) begin
            tbl[5 + k] = '{l: 1'b1, s: 1'b0, r: 1'b0,
                           ep: (k < SYNC_N + STAB_N),
                           ec: (k < SYNC_N + STAB_N + CORE_N),
                           er: (k >= SYNC_N + STAB_N + CORE_N)};
        end
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].l, tbl[i].s, tbl[i].r, tbl[i].ep, tbl[i].ec, tbl[i].er,
                  (i < 6) ? "reset_idle" : "clean_bringup");
        end

        // Lock loss in RUN, then a full re-lock sequence.
        drop_from_run(4, "loss_run");
        bringup(16, SYNC_N, "relock");

        // Glitchy lock: 5 high, 1 low, then a full fresh stabilise window.
        drop_from_run(4, "loss_before_glitch");
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "glitch_high");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "glitch_low");
        bringup(16, SYNC_N, "glitch_relock");

        // Software reset in RUN: immediate, uncounted, restarts with lock_s=1.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "sw_run");
        bringup(STAB_N, 0, "sw_restart");

        // Now in PERIPH_UP; lock drop reaches lock_s together with sw request.
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "simul_pre1");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "simul_pre2");
        bump_loss();
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "simul_abort");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "simul_post");

        // Five lock losses in RUN drive the counter into saturation.
        for (int i = 0; i < 5; i++) begin
            bringup(16, SYNC_N, "sat_bringup");
            drop_from_run(4, "sat_loss");
        end

        // rst while in PERIPH_UP: reset values next cycle despite lock.
        bringup(12, SYNC_N, "to_periph_up");
        loss_exp = 0;
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "rst_periph_up");
        bringup(16, SYNC_N, "post_rst_bringup");
        drop_from_run(4, "post_rst_loss");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
